// File: rtl/if_id_pipe_reg.sv
// ============================================================================
//  Module   : if_id_pipe_reg
//  Purpose  : IF/ID pipeline register with valid/ready handshake, stall,
//             flush and NOP bubble. Define IF_ID_PIPE_REG_SKID_EN for the
//             2-entry skid buffer with a registered in_ready.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_id_pipe_reg #(
    parameter int          XLEN = 32,
    parameter int          ILEN = 32,
    parameter logic [31:0] NOP  = 32'h00000013
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [ILEN-1:0] in_ins,
    input  logic            stall,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [ILEN-1:0] out_ins,
    output logic [1:0]      count
);

    localparam logic [ILEN-1:0] c_nop_ins = ILEN'(NOP);

    logic            r_vld;
    logic [XLEN-1:0] r_pc;
    logic [ILEN-1:0] r_ins;
    logic            w_drain;
    logic            w_accept;

    assign w_drain  = r_vld && out_ready && !stall;
    assign w_accept = in_valid && in_ready;

`ifdef IF_ID_PIPE_REG_SKID_EN
    logic            r_skid_vld;
    logic [XLEN-1:0] r_skid_pc;
    logic [ILEN-1:0] r_skid_ins;

    // Ready depends only on state (and flush), so no path from decode back-pressure.
    assign in_ready = !r_skid_vld || flush;
    assign count    = {1'b0, r_vld} + {1'b0, r_skid_vld};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vld      <= 1'b0;
            r_pc       <= '0;
            r_ins      <= c_nop_ins;
            r_skid_vld <= 1'b0;
            r_skid_pc  <= '0;
            r_skid_ins <= c_nop_ins;
        end else if (flush) begin
            r_vld      <= 1'b0;
            r_skid_vld <= 1'b0;
        end else if (r_skid_vld) begin
            // Skid full implies in_ready=0, so only the skid->main move can happen.
            if (w_drain) begin
                r_pc       <= r_skid_pc;
                r_ins      <= r_skid_ins;
                r_skid_vld <= 1'b0;
            end
        end else if (w_accept) begin
            if (!r_vld || w_drain) begin
                r_pc  <= in_pc;
                r_ins <= in_ins;
                r_vld <= 1'b1;
            end else begin
                r_skid_pc  <= in_pc;
                r_skid_ins <= in_ins;
                r_skid_vld <= 1'b1;
            end
        end else if (w_drain) begin
            r_vld <= 1'b0;
        end
    end
`else
    assign in_ready = !r_vld || (out_ready && !stall) || flush;
    assign count    = {1'b0, r_vld};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vld <= 1'b0;
            r_pc  <= '0;
            r_ins <= c_nop_ins;
        end else if (flush) begin
            r_vld <= 1'b0;
        end else if (w_accept) begin
            r_pc  <= in_pc;
            r_ins <= in_ins;
            r_vld <= 1'b1;
        end else if (w_drain) begin
            r_vld <= 1'b0;
        end
    end
`endif

    assign out_valid = r_vld;
    assign out_pc    = r_pc;
    assign out_ins   = r_vld ? r_ins : c_nop_ins;

endmodule

`default_nettype wire

// File: tb/tb_if_id_pipe_reg.sv
// ============================================================================
//  Module   : tb_if_id_pipe_reg
//  Purpose  : Directed self-checking bench for if_id_pipe_reg.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_id_pipe_reg;

    localparam logic [31:0] c_nop = 32'h00000013;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_ins;
    logic        stall;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_ins;
    logic [1:0]  count;

    int n_checks;
    int n_fail;

    logic [31:0] s_pc  [3];
    logic [31:0] s_ins [3];
    logic [31:0] bp_pc [3];
    logic [31:0] bp_ins[3];
    int          send_idx;
    int          recv_idx;

    if_id_pipe_reg dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_ins    (in_ins),
        .stall     (stall),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_ins   (out_ins),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One handshake cycle of the back-pressure sequence; outputs captured before the edge.
    task automatic bp_cycle();
        logic        acc_in, acc_out;
        logic [31:0] cap_pc, cap_ins;
        in_valid = (send_idx < 3);
        if (send_idx < 3) begin
            in_pc  = bp_pc[send_idx];
            in_ins = bp_ins[send_idx];
        end
        #1;
        acc_in  = in_valid && in_ready;
        acc_out = out_valid && out_ready && !stall;
        cap_pc  = out_pc;
        cap_ins = out_ins;
        @(posedge clk);
        #1;
        if (acc_in) send_idx++;
        if (acc_out) begin
            if (recv_idx < 3) begin
                check_val("bp_order_pc",  64'(cap_pc),  64'(bp_pc[recv_idx]));
                check_val("bp_order_ins", 64'(cap_ins), 64'(bp_ins[recv_idx]));
            end
            recv_idx++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        s_pc   = '{32'h0, 32'h4, 32'h8};
        s_ins  = '{32'h00500093, 32'h00A00113, 32'h002081B3};
        bp_pc  = '{32'h10, 32'h14, 32'h18};
        bp_ins = '{32'h11111111, 32'h22222222, 32'h33333333};

        // Reset with fetch presenting a beat
        reset = 1'b1; in_valid = 1'b1; in_pc = 32'h99; in_ins = 32'hDEADBEEF;
        stall = 1'b0; flush = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_out_valid", 64'(out_valid), 64'd0);
        check_val("rst_out_pc",    64'(out_pc),    64'd0);
        check_val("rst_out_ins",   64'(out_ins),   64'(c_nop));
        check_val("rst_count",     64'(count),     64'd0);
        reset = 1'b0; in_valid = 1'b0;
        #1;
        check_val("rst_in_ready",  64'(in_ready),  64'd1);

        // Streaming, one beat per cycle
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_pc = s_pc[i]; in_ins = s_ins[i];
            tick();
            check_val("stream_valid", 64'(out_valid), 64'd1);
            check_val("stream_pc",    64'(out_pc),    64'(s_pc[i]));
            check_val("stream_ins",   64'(out_ins),   64'(s_ins[i]));
        end
        in_valid = 1'b0;
        tick();
        check_val("stream_empty_valid", 64'(out_valid), 64'd0);
        check_val("stream_empty_ins",   64'(out_ins),   64'(c_nop));

        // Back-pressure: decode not ready for 4 cycles
        send_idx = 0; recv_idx = 0; out_ready = 1'b0;
        repeat (4) bp_cycle();
`ifdef IF_ID_PIPE_REG_SKID_EN
        check_val("bp_count", 64'(count), 64'd2);
`else
        check_val("bp_count", 64'(count), 64'd1);
`endif
        check_val("bp_in_ready", 64'(in_ready), 64'd0);
        check_val("bp_head_pc",  64'(out_pc),   64'h10);
        out_ready = 1'b1;
        repeat (6) bp_cycle();
        check_val("bp_recv_total", 64'(recv_idx),  64'd3);
        check_val("bp_drained",    64'(out_valid), 64'd0);
        in_valid = 1'b0;

        // Stall holds the entry bit-exact
        out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'h50; in_ins = 32'h55555555;
        tick();
        in_valid = 1'b0; stall = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("stall_pc",    64'(out_pc),  64'h50);
            check_val("stall_ins",   64'(out_ins), 64'h55555555);
            check_val("stall_count", 64'(count),   64'd1);
        end
        stall = 1'b0;
        tick();
        check_val("unstall_valid", 64'(out_valid), 64'd0);
        check_val("unstall_count", 64'(count),     64'd0);

        // Flush with a beat offered in the same cycle
        out_ready = 1'b0;
        in_valid = 1'b1; in_pc = 32'h60; in_ins = 32'h66666666;
        tick();
        in_pc = 32'h64; in_ins = 32'h64646464;
        tick();
`ifdef IF_ID_PIPE_REG_SKID_EN
        check_val("pre_flush_count", 64'(count), 64'd2);
`else
        check_val("pre_flush_count", 64'(count), 64'd1);
`endif
        flush = 1'b1; in_pc = 32'h20; in_ins = 32'h20202020;
        #1;
        check_val("flush_in_ready", 64'(in_ready), 64'd1);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check_val("flush_valid", 64'(out_valid), 64'd0);
        check_val("flush_ins",   64'(out_ins),   64'(c_nop));
        check_val("flush_count", 64'(count),     64'd0);
        in_valid = 1'b1; in_pc = 32'h40; in_ins = 32'h40404040; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check_val("post_flush_pc",  64'(out_pc),  64'h40);
        check_val("post_flush_ins", 64'(out_ins), 64'h40404040);
        tick();
        check_val("post_flush_empty", 64'(out_valid), 64'd0);

        // Flush beats a simultaneous stall
        out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'h70; in_ins = 32'h77777777;
        tick();
        in_valid = 1'b0; stall = 1'b1; flush = 1'b1;
        tick();
        stall = 1'b0; flush = 1'b0;
        check_val("flush_stall_valid", 64'(out_valid), 64'd0);
        check_val("flush_stall_count", 64'(count),     64'd0);

        // Asynchronous reset between edges mid-stream
        out_ready = 1'b1; in_valid = 1'b1; in_pc = 32'h74; in_ins = 32'h74747474;
        tick();
        check_val("pre_areset_valid", 64'(out_valid), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check_val("areset_valid", 64'(out_valid), 64'd0);
        check_val("areset_pc",    64'(out_pc),    64'd0);
        check_val("areset_ins",   64'(out_ins),   64'(c_nop));
        check_val("areset_count", 64'(count),     64'd0);
        #1;
        reset = 1'b0; in_pc = 32'h80; in_ins = 32'h80808080;
        tick();
        in_valid = 1'b0;
        check_val("restart_valid", 64'(out_valid), 64'd1);
        check_val("restart_pc",    64'(out_pc),    64'h80);
        check_val("restart_ins",   64'(out_ins),   64'h80808080);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
